// File: rtl/wbframefetch_if.sv
// rtl/wbframefetch_if.sv - Pipelined Wishbone read-only bus between the fetch engine and memory
interface wbframefetch_if #(
    parameter int AW = 24,
    parameter int DW = 64
) ();
    logic          cyc;
    logic          stb;
    logic [AW-1:0] addr;
    logic          ack;
    logic          stall;
    logic          err;
    logic [DW-1:0] data;

    modport master (output cyc, stb, addr, input ack, stall, err, data);
    modport slave  (input cyc, stb, addr, output ack, stall, err, data);
endinterface

// File: rtl/wbframefetch.sv
// rtl/wbframefetch.sv - Wishbone frame-buffer fetch engine feeding the VGA timing generator
module wbframefetch #(
    parameter int AW     = 24,
    parameter int DW     = 64,
    parameter int BPC    = 8,
    parameter int LGFIFO = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_en,
    input  logic               i_newframe,
    input  logic [AW-1:0]      i_base_addr,
    input  logic [AW-1:0]      i_line_addr,
    input  logic [11:0]        i_hm_width,
    input  logic [11:0]        i_vm_height,
    wbframefetch_if.master     wb,
    input  logic               i_rd,
    output logic [3*BPC-1:0]   o_pixel,
    output logic               o_underflow,
    output logic               o_err
);
    localparam int PPW   = DW / 32;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int CW    = LGFIFO + 1;
    localparam int SW    = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PXW   = 3 * BPC;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_t;

    state_t            state, state_n;
    logic [AW-1:0]     line_base, line_base_n, addr_r, addr_n;
    logic [11:0]       word, word_n, line, line_n, nwords;
    logic [CW-1:0]     outstanding, outst_n, fill, fill_after;
    logic              cyc_r, cyc_n, stb_r, stb_n, err_n;
    logic              accept, ack_in, push, pop, clear, credit_ok;
    logic [DW-1:0]     mem [DEPTH];
    logic [LGFIFO-1:0] wptr, rptr;
    logic [SW-1:0]     sub;
    logic [PXW-1:0]    pix_next;

    assign nwords     = 12'(i_hm_width / 12'(PPW));
    assign accept     = stb_r && !wb.stall;
    assign ack_in     = cyc_r && wb.ack && !wb.err;
    assign pop        = i_rd && (fill != '0) && (sub == SW'(PPW - 1));
    assign fill_after = fill + CW'(ack_in) - CW'(pop);
    // Slot 0 sits in the top 32 bits of the bus word.
    assign pix_next   = PXW'(mem[rptr] >> (32 * (PPW - 1 - int'(sub))));

    assign wb.cyc  = cyc_r;
    assign wb.stb  = stb_r;
    assign wb.addr = addr_r;

    always_comb begin
        state_n     = state;
        line_base_n = line_base;
        word_n      = word;
        line_n      = line;
        outst_n     = outstanding;
        cyc_n       = cyc_r;
        stb_n       = stb_r;
        addr_n      = addr_r;
        err_n       = 1'b0;
        push        = 1'b0;
        clear       = 1'b0;
        credit_ok   = 1'b0;
        if (!i_en) begin
            state_n     = IDLE;
            line_base_n = '0;
            word_n      = '0;
            line_n      = '0;
            outst_n     = '0;
            cyc_n       = 1'b0;
            stb_n       = 1'b0;
            addr_n      = '0;
            clear       = 1'b1;
        end else if (i_newframe) begin
            // An open cycle is abandoned; the fresh frame starts on the following edge.
            state_n     = FETCH;
            line_base_n = i_base_addr;
            word_n      = '0;
            line_n      = '0;
            outst_n     = '0;
            clear       = 1'b1;
            stb_n       = !cyc_r;
            cyc_n       = !cyc_r;
            addr_n      = i_base_addr;
        end else if (cyc_r && wb.err) begin
            state_n = DONE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            outst_n = '0;
            err_n   = 1'b1;
        end else if (state == FETCH || state == FLUSH) begin
            push    = ack_in;
            word_n  = word + 12'(accept);
            outst_n = outstanding + CW'(accept) - CW'(ack_in);
            if (state == FLUSH && outstanding == '0) begin
                line_base_n = line_base + i_line_addr;
                word_n      = '0;
                line_n      = line + 12'd1;
                state_n     = (line_n == i_vm_height) ? DONE : FETCH;
            end else if (word_n == nwords) begin
                state_n = FLUSH;
            end
            credit_ok = ({1'b0, fill_after} + {1'b0, outst_n}) < (CW + 1)'(DEPTH);
            stb_n     = (state_n == FETCH) && (word_n < nwords) && credit_ok;
            cyc_n     = stb_n || (outst_n != '0);
            addr_n    = line_base_n + AW'(word_n);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            line_base   <= '0;
            word        <= '0;
            line        <= '0;
            outstanding <= '0;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            addr_r      <= '0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_n;
            line_base   <= line_base_n;
            word        <= word_n;
            line        <= line_n;
            outstanding <= outst_n;
            cyc_r       <= cyc_n;
            stb_r       <= stb_n;
            addr_r      <= addr_n;
            o_err       <= err_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wptr] <= wb.data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
            sub  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
            sub  <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            fill <= fill + CW'(push) - CW'(pop);
            if (i_rd && fill != '0)
                sub <= (sub == SW'(PPW - 1)) ? '0 : sub + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pixel     <= '0;
            o_underflow <= 1'b0;
        end else if (!i_en) begin
            o_pixel     <= '0;
            o_underflow <= 1'b0;
        end else begin
            o_underflow <= i_rd && (fill == '0);
            if (i_rd)
                o_pixel <= (fill == '0) ? '0 : pix_next;
        end
    end
endmodule

// File: tb/tb_wbframefetch.sv
// tb/tb_wbframefetch.sv - Directed self-checking bench for wbframefetch
module tb_wbframefetch;
    localparam int AW = 24;
    localparam int DW = 64;
    localparam int BPC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic newframe = 1'b0;
    logic rd = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] line_addr = '0;
    logic [11:0] hm_width = '0;
    logic [11:0] vm_height = '0;
    logic [3*BPC-1:0] pixel;
    logic underflow;
    logic err;

    int checks = 0;
    int errors = 0;

    logic hold = 1'b0;
    logic use_ovr = 1'b0;
    logic [DW-1:0] ovr_data = '0;
    int err_at = 0;
    int ack_cnt = 0;
    logic gap_seen = 1'b0;
    logic [AW-1:0] pend[$];
    logic [AW-1:0] reqs[$];
    logic [AW-1:0] slv_a;

    wbframefetch_if #(.AW(AW), .DW(DW)) wb ();

    wbframefetch #(.AW(AW), .DW(DW), .BPC(BPC), .LGFIFO(5)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_en        (en),
        .i_newframe  (newframe),
        .i_base_addr (base_addr),
        .i_line_addr (line_addr),
        .i_hm_width  (hm_width),
        .i_vm_height (vm_height),
        .wb          (wb),
        .i_rd        (rd),
        .o_pixel     (pixel),
        .o_underflow (underflow),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
        return {8'hA0, a, 8'hB0, ~a};
    endfunction

    // Pipelined slave: ack the edge after acceptance unless held; forget everything when cyc drops.
    always @(posedge clk) begin
        wb.ack <= 1'b0;
        wb.err <= 1'b0;
        if (!wb.cyc) begin
            pend.delete();
        end else begin
            if (wb.stb && !wb.stall) begin
                pend.push_back(wb.addr);
                reqs.push_back(wb.addr);
            end
            if (!hold && pend.size() > 0) begin
                slv_a = pend.pop_front();
                ack_cnt++;
                if (ack_cnt == err_at) begin
                    wb.err <= 1'b1;
                end else begin
                    wb.ack  <= 1'b1;
                    wb.data <= use_ovr ? ovr_data : mk(slv_a);
                end
            end
        end
        if (reqs.size() == 4 && !wb.cyc)
            gap_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] s,
                               input logic [11:0] w, input logic [11:0] h);
        base_addr = b;
        line_addr = s;
        hm_width  = w;
        vm_height = h;
        reqs.delete();
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
    endtask

    task automatic test_reset();
        wb.stall = 1'b0;
        tick();
        tick();
        checks++; if (wb.cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b exp 0", wb.cyc); end
        checks++; if (wb.stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", wb.stb); end
        checks++; if (wb.addr !== 24'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", wb.addr); end
        checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL reset_pixel got %h exp 0", pixel); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        rst_n = 1'b1;
        en = 1'b1;
        tick();
    endtask

    task automatic test_underflow();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse got %b exp 1", underflow); end
        checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL uf_pixel got %h exp 0", pixel); end
        tick();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_single got %b exp 0", underflow); end
    endtask

    task automatic test_lines();
        logic [AW-1:0] exp_a [8];
        exp_a = '{24'h100, 24'h101, 24'h102, 24'h103, 24'h110, 24'h111, 24'h112, 24'h113};
        gap_seen = 1'b0;
        start_frame(24'h100, 24'h10, 12'd8, 12'd2);
        checks++; if (wb.stb !== 1'b1 || wb.addr !== 24'h100)
            begin errors++; $display("FAIL first_stb got stb=%b addr=%h exp stb=1 addr=100", wb.stb, wb.addr); end
        for (int i = 0; i < 100; i++) begin
            if (reqs.size() >= 8 && !wb.cyc) break;
            tick();
        end
        repeat (10) tick();
        checks++; if (reqs.size() !== 8) begin errors++; $display("FAIL lines_count got %0d exp 8", reqs.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < reqs.size()) begin
                checks++; if (reqs[i] !== exp_a[i])
                    begin errors++; $display("FAIL lines_addr%0d got %h exp %h", i, reqs[i], exp_a[i]); end
            end
        end
        checks++; if (gap_seen !== 1'b1) begin errors++; $display("FAIL line_gap got %b exp 1", gap_seen); end
        checks++; if (wb.cyc !== 1'b0) begin errors++; $display("FAIL done_cyc got %b exp 0", wb.cyc); end
        rd = 1'b1;
        tick();
        checks++; if (pixel !== 24'h000100) begin errors++; $display("FAIL lines_pix0 got %h exp 000100", pixel); end
        tick();
        checks++; if (pixel !== 24'hFFFEFF) begin errors++; $display("FAIL lines_pix1 got %h exp fffeff", pixel); end
        tick();
        rd = 1'b0;
        checks++; if (pixel !== 24'h000101) begin errors++; $display("FAIL lines_pix2 got %h exp 000101", pixel); end
    endtask

    task automatic test_unpack();
        use_ovr = 1'b1;
        ovr_data = 64'h11223344_55667788;
        start_frame(24'h300, 24'h0, 12'd2, 12'd1);
        for (int i = 0; i < 50; i++) begin
            if (reqs.size() >= 1 && !wb.cyc) break;
            tick();
        end
        tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (pixel !== 24'h223344) begin errors++; $display("FAIL unpack_slot0 got %h exp 223344", pixel); end
        tick();
        checks++; if (pixel !== 24'h223344) begin errors++; $display("FAIL unpack_hold got %h exp 223344", pixel); end
        rd = 1'b1;
        tick();
        checks++; if (pixel !== 24'h667788) begin errors++; $display("FAIL unpack_slot1 got %h exp 667788", pixel); end
        tick();
        rd = 1'b0;
        checks++; if (underflow !== 1'b1 || pixel !== 24'h0)
            begin errors++; $display("FAIL unpack_popped got uf=%b pix=%h exp uf=1 pix=0", underflow, pixel); end
        use_ovr = 1'b0;
    endtask

    task automatic test_credit();
        hold = 1'b1;
        start_frame(24'h1000, 24'h0, 12'd320, 12'd1);
        repeat (60) tick();
        checks++; if (reqs.size() !== 32) begin errors++; $display("FAIL credit_held got %0d exp 32", reqs.size()); end
        checks++; if (wb.stb !== 1'b0 || wb.cyc !== 1'b1)
            begin errors++; $display("FAIL credit_bus got stb=%b cyc=%b exp stb=0 cyc=1", wb.stb, wb.cyc); end
        hold = 1'b0;
        repeat (20) tick();
        checks++; if (reqs.size() !== 32) begin errors++; $display("FAIL credit_full got %0d exp 32", reqs.size()); end
        rd = 1'b1;
        tick();
        tick();
        rd = 1'b0;
        repeat (5) tick();
        checks++; if (reqs.size() !== 33) begin errors++; $display("FAIL credit_refill got %0d exp 33", reqs.size()); end
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
    endtask

    task automatic test_err();
        int n;
        logic seen;
        seen = 1'b0;
        ack_cnt = 0;
        err_at = 3;
        start_frame(24'h200, 24'h0, 12'd16, 12'd1);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (err) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", seen); end
        checks++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0)
            begin errors++; $display("FAIL err_drop got cyc=%b stb=%b exp 0 0", wb.cyc, wb.stb); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_single got %b exp 0", err); end
        n = reqs.size();
        repeat (10) tick();
        checks++; if (reqs.size() !== n || wb.cyc !== 1'b0)
            begin errors++; $display("FAIL err_quiet got reqs=%0d cyc=%b exp reqs=%0d cyc=0", reqs.size(), wb.cyc, n); end
        rd = 1'b1;
        tick();
        checks++; if (pixel !== 24'h000200) begin errors++; $display("FAIL err_fifo got %h exp 000200", pixel); end
        repeat (4) tick();
        rd = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL err_kept2 got %b exp 1", underflow); end
        err_at = 0;
    endtask

    task automatic test_newframe_abort();
        hold = 1'b1;
        start_frame(24'h400, 24'h0, 12'd320, 12'd1);
        for (int i = 0; i < 20; i++) begin
            if (reqs.size() >= 5) break;
            tick();
        end
        hold = 1'b0;
        tick();
        base_addr = 24'h800;
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        checks++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0)
            begin errors++; $display("FAIL abort_drop got cyc=%b stb=%b exp 0 0", wb.cyc, wb.stb); end
        tick();
        checks++; if (wb.stb !== 1'b1 || wb.addr !== 24'h800)
            begin errors++; $display("FAIL abort_restart got stb=%b addr=%h exp stb=1 addr=800", wb.stb, wb.addr); end
        repeat (10) tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (pixel !== 24'h000800) begin errors++; $display("FAIL abort_stale got %h exp 000800", pixel); end
    endtask

    task automatic test_async_reset();
        start_frame(24'h10, 24'h0, 12'd8, 12'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || wb.addr !== 24'h0)
            begin errors++; $display("FAIL async_rst got cyc=%b stb=%b addr=%h exp 0 0 0", wb.cyc, wb.stb, wb.addr); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_lines();
        test_unpack();
        test_credit();
        test_err();
        test_newframe_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
